// File: rtl/pulse_burst_ctrl.sv
// Pulse-train burst controller: bursts of N pulses or a continuous train. Define
// PULSE_BURST_POL_EN to add a cfg_pol input that inverts the output level.
`timescale 1ns/1ps

module pulse_burst_ctrl #(
    parameter int unsigned W          = 31,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DEF_PERIOD = 50000000
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [W-1:0]     cfg_period,
    input  logic [W-1:0]     cfg_high,
    input  logic [CNT_W-1:0] cfg_count,
`ifdef PULSE_BURST_POL_EN
    input  logic             cfg_pol,
`endif
    input  logic             start,
    input  logic             stop,
    output logic             pulse_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_left,
    output logic             err
);

    localparam logic [W-1:0] DefPeriod = W'(DEF_PERIOD);
    localparam logic [W-1:0] DefHigh   = W'(DEF_PERIOD / 2);

    typedef enum logic [1:0] {
        StIdle,
        StRunLow,
        StRunHigh
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     period_q, period_d;
    logic [W-1:0]     high_q, high_d;
    logic [W-1:0]     phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             pulse_q, pulse_d;
    logic             stop_pend_q, stop_pend_d;
    logic             run_high;

`ifdef PULSE_BURST_POL_EN
    logic             pol_q, pol_d;
`endif

    logic             cfg_xfer;
    logic             cfg_legal;
    logic [W-1:0]     low_len;

    assign busy        = (state_q != StIdle);
    assign cfg_ready   = ~busy;
    assign cfg_xfer    = cfg_valid & cfg_ready;
    assign cfg_legal   = (cfg_period >= W'(2)) && (cfg_high != '0) && (cfg_high < cfg_period);
    assign low_len     = period_q - high_q;

    assign pulse_o     = pulse_q;
    assign done        = done_q;
    assign pulses_left = left_q;
    assign err         = err_q;

    // Configuration bank; only reachable while idle since cfg_ready is ~busy.
    always_comb begin
        period_d = period_q;
        high_d   = high_q;
        count_d  = count_q;
        err_d    = err_q;
`ifdef PULSE_BURST_POL_EN
        pol_d    = pol_q;
`endif
        if (cfg_xfer) begin
            if (cfg_legal) begin
                period_d = cfg_period;
                high_d   = cfg_high;
                count_d  = cfg_count;
                err_d    = 1'b0;
`ifdef PULSE_BURST_POL_EN
                pol_d    = cfg_pol;
`endif
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        left_d      = left_q;
        stop_pend_d = stop_pend_q;

        unique case (state_q)
            StIdle: begin
                phase_d     = '0;
                left_d      = '0;
                stop_pend_d = 1'b0;
                // A same-cycle legal config is used by the new run; an illegal one vetoes it.
                if (start && !stop && !(cfg_xfer && !cfg_legal)) begin
                    state_d = StRunLow;
                    left_d  = count_d;
                end
            end
            StRunLow: begin
                if (stop) begin
                    state_d = StIdle;
                    phase_d = '0;
                    left_d  = '0;
                end else if (phase_q == low_len - W'(1)) begin
                    state_d = StRunHigh;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + W'(1);
                end
            end
            StRunHigh: begin
                // A stop during high is remembered so the pulse is never truncated.
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (phase_q == high_q - W'(1)) begin
                    phase_d = '0;
                    if (stop || stop_pend_q || ((count_q != '0) && (left_q == CNT_W'(1)))) begin
                        state_d = StIdle;
                        left_d  = '0;
                    end else begin
                        state_d = StRunLow;
                        if (count_q != '0) begin
                            left_d = left_q - CNT_W'(1);
                        end
                    end
                end else begin
                    phase_d = phase_q + W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
                left_d  = '0;
            end
        endcase
    end

    assign run_high = (state_d == StRunHigh);

    always_comb begin
        done_d = busy && (state_d == StIdle);
`ifdef PULSE_BURST_POL_EN
        pulse_d = run_high ^ pol_d;
`else
        pulse_d = run_high;
`endif
    end

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            period_q    <= DefPeriod;
            high_q      <= DefHigh;
            phase_q     <= '0;
            count_q     <= '0;
            left_q      <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            pulse_q     <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            high_q      <= high_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
            left_q      <= left_d;
            err_q       <= err_d;
            done_q      <= done_d;
            pulse_q     <= pulse_d;
            stop_pend_q <= stop_pend_d;
        end
    end

`ifdef PULSE_BURST_POL_EN
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            pol_q <= 1'b0;
        end else begin
            pol_q <= pol_d;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Bench for pulse_burst_ctrl: directed scenarios plus random traffic, checked every
// cycle against a burst-timeline model (elapsed cycles into the burst).
`timescale 1ns/1ps

module tb_pulse_burst_ctrl;

    localparam int unsigned W     = 31;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DEF_P = 40;

    logic             clki = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [W-1:0]     cfg_period = '0;
    logic [W-1:0]     cfg_high = '0;
    logic [CNT_W-1:0] cfg_count = '0;
`ifdef PULSE_BURST_POL_EN
    logic             cfg_pol = 1'b0;
`endif
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             pulse_o;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_left;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    pulse_burst_ctrl #(
        .W          (W),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_P)
    ) dut (
        .clki        (clki),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_count   (cfg_count),
`ifdef PULSE_BURST_POL_EN
        .cfg_pol     (cfg_pol),
`endif
        .start       (start),
        .stop        (stop),
        .pulse_o     (pulse_o),
        .busy        (busy),
        .done        (done),
        .pulses_left (pulses_left),
        .err         (err)
    );

    always #5 clki = ~clki;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst is a timeline; m_t counts cycles since it began.
    int m_period, m_high, m_count, m_t, m_end;
    bit m_run, m_done, m_err, m_pol, m_stop_seen;

    initial begin
        int ph, nend, p, h;
        bit bad, legal, fin;
        forever begin
            @(posedge clki or posedge rst);
            if (rst) begin
                m_period = DEF_P; m_high = DEF_P / 2; m_count = 0;
                m_run = 0; m_done = 0; m_err = 0; m_pol = 0;
                m_t = 0; m_end = -1; m_stop_seen = 0;
            end else begin
                fin = 0;
                if (m_run) begin
                    if (stop && !m_stop_seen) begin
                        m_stop_seen = 1;
                        ph = m_t % m_period;
                        if (ph < m_period - m_high) nend = m_t + 1;
                        else nend = (m_t / m_period + 1) * m_period;
                        if (m_end < 0 || nend < m_end) m_end = nend;
                    end
                    m_t++;
                    if (m_end >= 0 && m_t >= m_end) begin
                        m_run = 0;
                        fin = 1;
                    end
                end else begin
                    bad = 0;
                    if (cfg_valid) begin
                        p = int'(cfg_period);
                        h = int'(cfg_high);
                        legal = (p >= 2) && (h >= 1) && (h < p);
                        if (legal) begin
                            m_period = p; m_high = h; m_count = int'(cfg_count); m_err = 0;
`ifdef PULSE_BURST_POL_EN
                            m_pol = cfg_pol;
`endif
                        end else begin
                            m_err = 1;
                            bad = 1;
                        end
                    end
                    if (start && !stop && !bad) begin
                        m_run = 1; m_t = 0; m_stop_seen = 0;
                        m_end = (m_count != 0) ? m_count * m_period : -1;
                    end
                end
                m_done = fin;
            end
        end
    end

    // Every-cycle compare, away from the active edge.
    initial begin
        bit hi;
        int exp_left;
        forever begin
            @(negedge clki);
            if (chk_en) begin
                hi = m_run && ((m_t % m_period) >= (m_period - m_high));
                exp_left = (m_run && m_count != 0) ? m_count - m_t / m_period : 0;
                check("m_pulse_o", pulse_o, hi ^ m_pol);
                check("m_busy", busy, m_run);
                check("m_cfg_ready", cfg_ready, !m_run);
                check("m_done", done, m_done);
                check("m_pulses_left", pulses_left, exp_left);
                check("m_err", err, m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    task automatic send_cfg(input int p, input int h, input int c, input bit pol, input bit st);
        cfg_valid  = 1'b1;
        cfg_period = W'(p);
        cfg_high   = W'(h);
        cfg_count  = CNT_W'(c);
`ifdef PULSE_BURST_POL_EN
        cfg_pol    = pol;
`else
        if (pol) $display("note: polarity request ignored in this build");
`endif
        start      = st;
        tick();
        cfg_valid  = 1'b0;
        start      = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        if (busy) check("wait_idle_timeout", busy, 0);
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (pulse_o == 1'b0 && n < 500) begin
            n++;
            tick();
        end
    endtask

    task automatic stop_and_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(200);
    endtask

    initial begin
        int lowlen;
        logic [11:0] pat12;
        logic [9:0]  pat10;
        int busy_cnt;
`ifdef PULSE_BURST_POL_EN
        logic [3:0]  pat4;
`endif

        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clki);
        #1 rst = 1'b0;

        // Reset/idle values and the default period.
        repeat (10) tick();
        check("rst_pulse_o", pulse_o, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_err", err, 0);
        pulse_start();
        measure_low(lowlen);
        check("def_low_len", lowlen, DEF_P - DEF_P / 2);
        stop_and_idle();

        // Burst of 3 pulses, period 4, high 2.
        send_cfg(4, 2, 3, 0, 0);
        pulse_start();
        pat12 = '0;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            pat12 = {pat12[10:0], pulse_o};
            busy_cnt += int'(busy);
            if (i == 0) check("b3_left0", pulses_left, 3);
            if (i == 4) check("b3_left1", pulses_left, 2);
            if (i == 8) check("b3_left2", pulses_left, 1);
            tick();
        end
        check("b3_pattern", pat12, 12'b0011_0011_0011);
        check("b3_busy_cycles", busy_cnt, 12);
        check("b3_done", done, 1);
        check("b3_busy_end", busy, 0);
        tick();
        check("b3_done_once", done, 0);

        // Illegal config with start: start vetoed, err set.
        send_cfg(2, 2, 1, 0, 1);
        check("illegal_err", err, 1);
        check("illegal_no_start", busy, 0);

        // Continuous 5/1, config and start in the same cycle.
        send_cfg(5, 1, 0, 0, 1);
        check("legal_err_clear", err, 0);
        pat10 = '0;
        for (int i = 0; i < 10; i++) begin
            pat10 = {pat10[8:0], pulse_o};
            check("cont_left_zero", pulses_left, 0);
            tick();
        end
        check("cont_pattern", pat10, 10'b00001_00001);
        for (int i = 0; i < 20 && pulse_o == 1'b0; i++) tick();
        check("cont_high_seen", pulse_o, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("cont_stop_busy", busy, 0);
        check("cont_stop_done", done, 1);

        // Stop in 2nd low cycle of pulse 2; config offered mid-burst must be refused.
        send_cfg(6, 3, 3, 0, 0);
        pulse_start();
        repeat (7) tick();
        check("mid_pulses_left", pulses_left, 2);
        stop       = 1'b1;
        cfg_valid  = 1'b1;
        cfg_period = W'(9);
        cfg_high   = W'(4);
        cfg_count  = CNT_W'(1);
        check("mid_cfg_ready", cfg_ready, 0);
        tick();
        stop = 1'b0;
        cfg_valid = 1'b0;
        check("lowstop_busy", busy, 0);
        check("lowstop_done", done, 1);
        check("lowstop_pulse", pulse_o, 0);
        tick();
        check("lowstop_done_once", done, 0);
        pulse_start();
        measure_low(lowlen);
        check("cfg_not_taken_low", lowlen, 3);
        wait_idle(100);

        // Asynchronous reset during the high phase.
        send_cfg(8, 4, 5, 0, 0);
        pulse_start();
        for (int i = 0; i < 20 && pulse_o == 1'b0; i++) tick();
        tick();
        check("pre_rst_high", pulse_o, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pulse", pulse_o, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_left", pulses_left, 0);
        repeat (2) @(posedge clki);
        #1 rst = 1'b0;
        pulse_start();
        measure_low(lowlen);
        check("post_rst_low_len", lowlen, DEF_P - DEF_P / 2);
        stop_and_idle();

`ifdef PULSE_BURST_POL_EN
        send_cfg(4, 1, 1, 1, 0);
        check("pol_idle_level", pulse_o, 1);
        pulse_start();
        pat4 = '0;
        for (int i = 0; i < 4; i++) begin
            pat4 = {pat4[2:0], pulse_o};
            tick();
        end
        check("pol_pattern", pat4, 4'b1110);
        check("pol_idle_after", pulse_o, 1);
        check("pol_done", done, 1);
`endif

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            cfg_valid  = ($urandom_range(0, 7) == 0);
            cfg_period = W'($urandom_range(1, 9));
            cfg_high   = W'($urandom_range(0, 9));
            cfg_count  = CNT_W'($urandom_range(0, 3));
`ifdef PULSE_BURST_POL_EN
            cfg_pol    = 1'($urandom_range(0, 1));
`endif
            start      = ($urandom_range(0, 4) == 0);
            stop       = ($urandom_range(0, 29) == 0);
            tick();
        end
        cfg_valid = 1'b0;
        start = 1'b0;
        stop_and_idle();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pulse_burst_ctrl.md
Name: pulse_burst_ctrl

Overview:
- Programmable controller that sequences a pulse-train generator built on the team's counter-based clock-divider datapath.
- Holds period, high-time and burst-count configuration loaded over a valid/ready handshake.
- Runs start/stop-controlled bursts of N pulses, or a continuous train, and reports busy, done and error status.
- Sits between the control FSM/register bank and the pin or peripheral consuming the pulse.

Parameters:
- W, 31, width of period/high-time registers and the phase counter.
- CNT_W, 8, width of the burst-count and pulses-remaining fields.
- DEF_PERIOD, 50000000, period loaded at reset, in clki cycles.

Ports:
- clki  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted; equals ~busy.
- cfg_period  in  W  cycles per pulse; legal range 2 .. 2^W-1.
- cfg_high  in  W  high cycles per pulse; legal range 1 .. cfg_period-1.
- cfg_count  in  CNT_W  pulses per burst; 0 = continuous.
- start  in  1  begin a burst; level sampled each cycle.
- stop  in  1  abort request.
- pulse_o  out  1  registered pulse output.
- busy  out  1  burst in progress.
- done  out  1  one-cycle strobe when a burst ends (normal or stopped).
- pulses_left  out  CNT_W  remaining pulses including the current one; 0 in continuous mode or when idle.
- err  out  1  sticky flag: last offered config was illegal.

Behaviour:
- Reset values: pulse_o=0, busy=0, done=0, err=0, pulses_left=0, state=IDLE. Config registers: period=DEF_PERIOD, high=DEF_PERIOD/2, count=0.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - A legal config is latched and clears err.
  - An illegal config leaves the registers unchanged and sets err.
  - cfg_valid while busy is ignored; no error is raised.
- FSM states: IDLE, RUN_LOW, RUN_HIGH.
- IDLE -> RUN_LOW on start & ~stop.
  - Phase counter = 0; pulses_left = count.
  - busy=1 from the next cycle.
  - If a legal cfg transfers in the same cycle, the run uses the new values. If that cfg is illegal, start is ignored.
- RUN_LOW lasts (period-high) cycles with pulse_o=0, then -> RUN_HIGH with counter reset.
- RUN_HIGH lasts high cycles with pulse_o=1. At the end of the phase:
  - If count!=0 and pulses_left==1 -> IDLE.
  - Otherwise decrement pulses_left (only when count!=0) and -> RUN_LOW.
- pulse_o is a register equal to (state==RUN_HIGH). There are no combinational glitches.
- One pulse = exactly period cycles, low phase first. A burst holds busy for exactly count*period cycles.
- done = 1 for the single cycle after the transition into IDLE; busy=0 in that cycle.
- stop handling:
  - In RUN_LOW: -> IDLE next edge, done strobed, no partial high.
  - In RUN_HIGH: the current high phase completes in full, then -> IDLE with done. No truncated pulses.
  - In IDLE: no effect.
- start while busy is ignored. start held high after done starts a new burst on the first IDLE cycle.
- Phase counter is W bits and never overflows, because every legal value is < 2^W. Comparisons are unsigned.
- rst asserted mid-burst: immediate return to reset values, with pulse_o forced 0 asynchronously.

Optional Feature:
- Macro: PULSE_BURST_POL_EN.
- Defined:
  - Adds input cfg_pol (1 bit), latched with each legal config; reset value 0.
  - pulse_o = (state==RUN_HIGH) ^ pol_reg, so the idle level equals pol_reg. The reset level is still 0.
- Undefined: no cfg_pol port; active-high output only.

Test Plan:
- Reset then idle 10 cycles -> pulse_o=0, busy=0, cfg_ready=1, err=0; period reads as 50000000 via a continuous start with observation of the first low phase length = 25000000.
- Config period=4, high=2, count=3; start 1 cycle -> pulse_o pattern 0,0,1,1 ×3 over 12 busy cycles; pulses_left 3,2,1; done=1 on cycle 13 with busy=0.
- Config period=2, high=2 -> err=1, registers unchanged; then period=5, high=1, count=0, start -> continuous 0,0,0,0,1; stop during high -> high completes, done, IDLE.
- Burst period=6, high=3; assert stop in 2nd low cycle of pulse 2 -> IDLE next edge, pulse_o stays 0, done once; cfg_valid during burst -> not accepted (cfg_ready=0).
- Assert rst in the middle of the high phase -> pulse_o=0 immediately, busy=0, pulses_left=0; start after release runs with reset config.
- With PULSE_BURST_POL_EN: pol=1, period=4, high=1, count=1 -> idle 1, pattern 1,1,1,0, then idle 1.
